// File: rtl/stage_issue.sv
// stage_issue: CPU issue stage with scoreboard hazard stall, writeback forwarding and a registered issue channel
// Ports:
//   clk_i, reset_i              clock, synchronous active-high reset
//   decode_*_i / decode_ready_o decode channel: control word, PC, immediate, register indices, operand selects
//   rs1/rs2_addr_o, rs*_data_i  asynchronous register-file read port
//   wb_addr_i/wb_data_i/wb_valid_i  writeback bus, clears scoreboard entries and feeds forwarding
//   issue_*_o / issue_ready_i   registered issue channel toward execute
package stage_issue_pkg;
    typedef logic [31:0] control_word_t;
endpackage

module stage_issue
    import stage_issue_pkg::*;
#(
    parameter int MAX_IN_FLIGHT = 4,
    parameter bit WB_FORWARD    = 1'b1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  control_word_t decode_cw_i,
    input  logic [31:0]   decode_pc_i,
    input  logic [31:0]   decode_imm_i,
    input  logic [4:0]    decode_rs1_i,
    input  logic [4:0]    decode_rs2_i,
    input  logic          decode_rs1_used_i,
    input  logic          decode_rs2_used_i,
    input  logic [4:0]    decode_rd_i,
    input  logic          decode_rd_wr_i,
    input  logic          decode_op1_sel_i,
    input  logic          decode_op2_sel_i,
    input  logic          decode_valid_i,
    output logic          decode_ready_o,
    output logic [4:0]    rs1_addr_o,
    output logic [4:0]    rs2_addr_o,
    input  logic [31:0]   rs1_data_i,
    input  logic [31:0]   rs2_data_i,
    input  logic [4:0]    wb_addr_i,
    input  logic [31:0]   wb_data_i,
    input  logic          wb_valid_i,
    output control_word_t issue_cw_o,
    output logic [31:0]   issue_alu_op1_o,
    output logic [31:0]   issue_alu_op2_o,
    output logic          issue_valid_o,
    input  logic          issue_ready_i
);
    localparam int CW = $clog2(MAX_IN_FLIGHT + 1);

    logic [31:0]   pending, set_mask, clr_mask, rs1_val, rs2_val;
    logic [CW-1:0] count;
    logic          rs1_fwd, rs2_fwd, rd_fwd, wb_clears, full, hazard, accept, set_rd;

    assign rs1_addr_o = decode_rs1_i;
    assign rs2_addr_o = decode_rs2_i;

    // a same-cycle writeback to a register both resolves its hazard and supplies its data
    assign rs1_fwd = WB_FORWARD && wb_valid_i && wb_addr_i == decode_rs1_i;
    assign rs2_fwd = WB_FORWARD && wb_valid_i && wb_addr_i == decode_rs2_i;
    assign rd_fwd  = WB_FORWARD && wb_valid_i && wb_addr_i == decode_rd_i;

    assign rs1_val = decode_rs1_i == 5'd0 ? 32'd0 : rs1_fwd ? wb_data_i : rs1_data_i;
    assign rs2_val = decode_rs2_i == 5'd0 ? 32'd0 : rs2_fwd ? wb_data_i : rs2_data_i;

    assign wb_clears = wb_valid_i && wb_addr_i != 5'd0 && pending[wb_addr_i];
    // a full tracker still admits a new write when a pending entry retires this cycle
    assign full = count == CW'(MAX_IN_FLIGHT) && !(WB_FORWARD && wb_clears);

    assign hazard = (decode_rs1_used_i && decode_rs1_i != 5'd0 && pending[decode_rs1_i] && !rs1_fwd)
                 || (decode_rs2_used_i && decode_rs2_i != 5'd0 && pending[decode_rs2_i] && !rs2_fwd)
                 || (decode_rd_wr_i && decode_rd_i != 5'd0 && ((pending[decode_rd_i] && !rd_fwd) || full));

    assign decode_ready_o = (!issue_valid_o || issue_ready_i) && !hazard && !reset_i;
    assign accept         = decode_valid_i && decode_ready_o;
    assign set_rd         = accept && decode_rd_wr_i && decode_rd_i != 5'd0;

    // set is applied after clear so a same-register set/clear leaves the entry pending
    assign set_mask = {31'd0, set_rd} << decode_rd_i;
    assign clr_mask = {31'd0, wb_clears} << wb_addr_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pending         <= '0;
            count           <= '0;
            issue_valid_o   <= 1'b0;
            issue_cw_o      <= '0;
            issue_alu_op1_o <= '0;
            issue_alu_op2_o <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
            count   <= count + CW'(set_rd) - CW'(wb_clears);
            if (accept) begin
                issue_valid_o   <= 1'b1;
                issue_cw_o      <= decode_cw_i;
                issue_alu_op1_o <= decode_op1_sel_i ? decode_pc_i : rs1_val;
                issue_alu_op2_o <= decode_op2_sel_i ? decode_imm_i : rs2_val;
            end else if (issue_ready_i) begin
                issue_valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_stage_issue.sv
// tb_stage_issue: self-checking bench for stage_issue against a behavioural scoreboard model
module tb_stage_issue;
    import stage_issue_pkg::*;
    localparam int MAXF = 4;

    logic          clk = 1'b0;
    logic          reset_i;
    control_word_t decode_cw_i, issue_cw_o;
    logic [31:0]   decode_pc_i, decode_imm_i, rs1_data_i, rs2_data_i, wb_data_i;
    logic [31:0]   issue_alu_op1_o, issue_alu_op2_o;
    logic [4:0]    decode_rs1_i, decode_rs2_i, decode_rd_i, rs1_addr_o, rs2_addr_o, wb_addr_i;
    logic          decode_rs1_used_i, decode_rs2_used_i, decode_rd_wr_i, decode_op1_sel_i, decode_op2_sel_i;
    logic          decode_valid_i, decode_ready_o, wb_valid_i, issue_valid_o, issue_ready_i;

    logic [31:0]   rf [32];
    bit            mpend [32];
    logic          mvalid = 1'b0;
    control_word_t mcw = '0;
    logic [31:0]   mop1 = '0, mop2 = '0;
    int            total = 0, bad = 0;

    always #5 clk = ~clk;
    assign rs1_data_i = rf[rs1_addr_o];
    assign rs2_data_i = rf[rs2_addr_o];

    stage_issue #(.MAX_IN_FLIGHT(MAXF), .WB_FORWARD(1'b1)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .decode_cw_i(decode_cw_i), .decode_pc_i(decode_pc_i), .decode_imm_i(decode_imm_i),
        .decode_rs1_i(decode_rs1_i), .decode_rs2_i(decode_rs2_i),
        .decode_rs1_used_i(decode_rs1_used_i), .decode_rs2_used_i(decode_rs2_used_i),
        .decode_rd_i(decode_rd_i), .decode_rd_wr_i(decode_rd_wr_i),
        .decode_op1_sel_i(decode_op1_sel_i), .decode_op2_sel_i(decode_op2_sel_i),
        .decode_valid_i(decode_valid_i), .decode_ready_o(decode_ready_o),
        .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .wb_valid_i(wb_valid_i),
        .issue_cw_o(issue_cw_o), .issue_alu_op1_o(issue_alu_op1_o), .issue_alu_op2_o(issue_alu_op2_o),
        .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i)
    );

    function automatic logic [31:0] m_mask();
        logic [31:0] m = '0;
        for (int i = 0; i < 32; i++) m[i] = mpend[i];
        return m;
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(mpend[i]);
        return n;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (wb_valid_i && wb_addr_i == r) return wb_data_i;
        return rf[r];
    endfunction

    function automatic bit m_blocked(input logic [4:0] r);
        return r != 5'd0 && mpend[r] && !(wb_valid_i && wb_addr_i == r);
    endfunction

    function automatic bit m_ready();
        bit frees, hz;
        frees = wb_valid_i && wb_addr_i != 5'd0 && mpend[wb_addr_i];
        hz = (decode_rs1_used_i && m_blocked(decode_rs1_i)) || (decode_rs2_used_i && m_blocked(decode_rs2_i))
          || (decode_rd_wr_i && (m_blocked(decode_rd_i) || (decode_rd_i != 5'd0 && m_count() == MAXF && !frees)));
        return (!mvalid || issue_ready_i) && !hz && !reset_i;
    endfunction

    // advance the model with the inputs currently driven, then clock the DUT
    task automatic step();
        bit acc;
        acc = decode_valid_i && m_ready();
        if (reset_i) begin
            mvalid = 1'b0; mcw = '0; mop1 = '0; mop2 = '0;
            for (int i = 0; i < 32; i++) mpend[i] = 1'b0;
        end else begin
            if (acc) begin
                mvalid = 1'b1;
                mcw    = decode_cw_i;
                mop1   = decode_op1_sel_i ? decode_pc_i : m_read(decode_rs1_i);
                mop2   = decode_op2_sel_i ? decode_imm_i : m_read(decode_rs2_i);
            end else if (issue_ready_i) mvalid = 1'b0;
            if (wb_valid_i && wb_addr_i != 5'd0) mpend[wb_addr_i] = 1'b0;
            if (acc && decode_rd_wr_i && decode_rd_i != 5'd0) mpend[decode_rd_i] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        decode_valid_i = 0; decode_rs1_used_i = 0; decode_rs2_used_i = 0; decode_rd_wr_i = 0;
        decode_op1_sel_i = 0; decode_op2_sel_i = 0; decode_rs1_i = 0; decode_rs2_i = 0; decode_rd_i = 0;
        wb_valid_i = 0; wb_addr_i = 0; wb_data_i = 0; issue_ready_i = 1; reset_i = 0;
        decode_cw_i = $urandom; decode_pc_i = $urandom; decode_imm_i = $urandom;
    endtask

    task automatic test_reset();
        idle();
        reset_i = 1; decode_valid_i = 1;
        step(); step();
        total++; if (decode_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", decode_ready_o); end
        total++; if (issue_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", issue_valid_o); end
        total++; if (issue_cw_o !== 32'd0 || issue_alu_op1_o !== 32'd0 || issue_alu_op2_o !== 32'd0) begin
            bad++; $display("FAIL reset_word got=%h/%h/%h exp=0", issue_cw_o, issue_alu_op1_o, issue_alu_op2_o); end
        total++; if (dut.pending !== 32'd0 || dut.count !== 3'd0) begin
            bad++; $display("FAIL reset_sb got=%h/%0d exp=0/0", dut.pending, dut.count); end
        idle();
        step();
    endtask

    task automatic test_add();
        idle();
        rf[1] = 32'd5; rf[2] = 32'd7;
        decode_rs1_i = 1; decode_rs2_i = 2; decode_rs1_used_i = 1; decode_rs2_used_i = 1;
        decode_rd_i = 3; decode_rd_wr_i = 1; decode_valid_i = 1;
        #1;
        total++; if (decode_ready_o !== 1'b1) begin bad++; $display("FAIL add_ready got=%b exp=1", decode_ready_o); end
        total++; if (rs1_addr_o !== 5'd1 || rs2_addr_o !== 5'd2) begin
            bad++; $display("FAIL add_addr got=%0d/%0d exp=1/2", rs1_addr_o, rs2_addr_o); end
        step();
        total++; if (issue_valid_o !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", issue_valid_o); end
        total++; if (issue_alu_op1_o !== 32'd5 || issue_alu_op2_o !== 32'd7) begin
            bad++; $display("FAIL add_ops got=%0d/%0d exp=5/7", issue_alu_op1_o, issue_alu_op2_o); end
        total++; if (issue_cw_o !== mcw) begin bad++; $display("FAIL add_cw got=%h exp=%h", issue_cw_o, mcw); end
        total++; if (dut.pending !== 32'h8) begin bad++; $display("FAIL add_pending got=%h exp=8", dut.pending); end
        decode_valid_i = 0;
        step();
        total++; if (issue_valid_o !== 1'b0) begin bad++; $display("FAIL add_drain got=%b exp=0", issue_valid_o); end
    endtask

    task automatic test_raw_forward();
        idle();
        decode_rs1_i = 3; decode_rs1_used_i = 1; decode_valid_i = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (decode_ready_o !== 1'b0) begin bad++; $display("FAIL raw_stall c=%0d got=%b exp=0", c, decode_ready_o); end
            step();
        end
        wb_valid_i = 1; wb_addr_i = 3; wb_data_i = 32'hDEAD;
        #1;
        total++; if (decode_ready_o !== 1'b1) begin bad++; $display("FAIL raw_fwd_ready got=%b exp=1", decode_ready_o); end
        step();
        total++; if (issue_valid_o !== 1'b1 || issue_alu_op1_o !== 32'hDEAD) begin
            bad++; $display("FAIL raw_fwd_op1 got=%b/%h exp=1/0000dead", issue_valid_o, issue_alu_op1_o); end
        total++; if (dut.pending !== 32'd0) begin bad++; $display("FAIL raw_fwd_pending got=%h exp=0", dut.pending); end
        idle();
        step();
    endtask

    task automatic test_backpressure();
        control_word_t hcw;
        logic [31:0] h1, h2;
        idle();
        decode_op1_sel_i = 1; decode_op2_sel_i = 1; decode_valid_i = 1; issue_ready_i = 0;
        step();
        hcw = decode_cw_i; h1 = decode_pc_i; h2 = decode_imm_i;
        decode_cw_i = ~hcw; decode_pc_i = $urandom; decode_imm_i = $urandom;
        for (int c = 0; c < 5; c++) begin
            #1;
            total++; if (decode_ready_o !== 1'b0) begin bad++; $display("FAIL bp_ready c=%0d got=%b exp=0", c, decode_ready_o); end
            total++; if (issue_valid_o !== 1'b1 || issue_cw_o !== hcw || issue_alu_op1_o !== h1 || issue_alu_op2_o !== h2) begin
                bad++; $display("FAIL bp_hold c=%0d got=%b/%h/%h/%h exp=1/%h/%h/%h", c, issue_valid_o,
                                issue_cw_o, issue_alu_op1_o, issue_alu_op2_o, hcw, h1, h2); end
            step();
        end
        issue_ready_i = 1;
        #1;
        total++; if (decode_ready_o !== 1'b1) begin bad++; $display("FAIL bp_release got=%b exp=1", decode_ready_o); end
        step();
        total++; if (issue_valid_o !== 1'b1 || issue_cw_o !== ~hcw || issue_alu_op1_o !== mop1) begin
            bad++; $display("FAIL bp_next got=%b/%h exp=1/%h", issue_valid_o, issue_cw_o, ~hcw); end
        idle();
        step();
    endtask

    task automatic test_max_in_flight();
        idle();
        decode_rd_wr_i = 1; decode_valid_i = 1;
        for (int r = 4; r < 8; r++) begin
            decode_rd_i = 5'(r);
            #1;
            total++; if (decode_ready_o !== 1'b1) begin bad++; $display("FAIL mif_fill r=%0d got=%b exp=1", r, decode_ready_o); end
            step();
        end
        decode_rd_i = 8;
        for (int c = 0; c < 2; c++) begin
            #1;
            total++; if (decode_ready_o !== 1'b0) begin bad++; $display("FAIL mif_full c=%0d got=%b exp=0", c, decode_ready_o); end
            step();
        end
        wb_valid_i = 1; wb_addr_i = 4;
        #1;
        total++; if (decode_ready_o !== 1'b1) begin bad++; $display("FAIL mif_wb_ready got=%b exp=1", decode_ready_o); end
        step();
        total++; if (dut.count !== 3'd4 || dut.pending !== 32'h1E0) begin
            bad++; $display("FAIL mif_count got=%0d/%h exp=4/000001e0", dut.count, dut.pending); end
        decode_valid_i = 0;
        for (int r = 5; r < 9; r++) begin wb_addr_i = 5'(r); step(); end
        total++; if (dut.count !== 3'd0) begin bad++; $display("FAIL mif_drain got=%0d exp=0", dut.count); end
        idle();
        step();
    endtask

    task automatic test_x0();
        idle();
        rf[0] = 32'hBAD0_BAD0;
        decode_rd_wr_i = 1; decode_valid_i = 1;
        for (int r = 9; r < 13; r++) begin decode_rd_i = 5'(r); step(); end
        decode_rs1_i = 0; decode_rs2_i = 0; decode_rs1_used_i = 1; decode_rs2_used_i = 1; decode_rd_i = 0;
        wb_valid_i = 1; wb_addr_i = 0; wb_data_i = 32'h1234_5678;
        #1;
        total++; if (decode_ready_o !== 1'b1) begin bad++; $display("FAIL x0_ready got=%b exp=1", decode_ready_o); end
        step();
        total++; if (issue_alu_op1_o !== 32'd0 || issue_alu_op2_o !== 32'd0) begin
            bad++; $display("FAIL x0_ops got=%h/%h exp=0/0", issue_alu_op1_o, issue_alu_op2_o); end
        total++; if (dut.pending !== 32'h1E00 || dut.count !== 3'd4) begin
            bad++; $display("FAIL x0_sb got=%h/%0d exp=00001e00/4", dut.pending, dut.count); end
        decode_valid_i = 0;
        for (int r = 9; r < 13; r++) begin wb_addr_i = 5'(r); step(); end
        idle();
        step();
    endtask

    task automatic test_reset_mid();
        idle();
        decode_rd_i = 5; decode_rd_wr_i = 1; decode_valid_i = 1; issue_ready_i = 0;
        step();
        decode_valid_i = 0; reset_i = 1;
        step();
        reset_i = 0;
        total++; if (issue_valid_o !== 1'b0 || dut.pending !== 32'd0) begin
            bad++; $display("FAIL rmid_clear got=%b/%h exp=0/0", issue_valid_o, dut.pending); end
        idle();
        decode_rs1_i = 5; decode_rs1_used_i = 1; decode_valid_i = 1;
        #1;
        total++; if (decode_ready_o !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", decode_ready_o); end
        step();
        total++; if (issue_valid_o !== 1'b1 || issue_alu_op1_o !== rf[5]) begin
            bad++; $display("FAIL rmid_issue got=%b/%h exp=1/%h", issue_valid_o, issue_alu_op1_o, rf[5]); end
        idle();
        step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            decode_cw_i = $urandom; decode_pc_i = $urandom; decode_imm_i = $urandom;
            decode_rs1_i = 5'($urandom_range(7)); decode_rs2_i = 5'($urandom_range(7)); decode_rd_i = 5'($urandom_range(7));
            decode_rs1_used_i = 1'($urandom); decode_rs2_used_i = 1'($urandom); decode_rd_wr_i = 1'($urandom);
            decode_op1_sel_i = 1'($urandom); decode_op2_sel_i = 1'($urandom);
            decode_valid_i = ($urandom % 4) != 0; issue_ready_i = ($urandom % 3) != 0;
            wb_valid_i = 1'($urandom); wb_addr_i = 5'($urandom_range(7)); wb_data_i = $urandom;
            reset_i = ($urandom % 64) == 0;
            #1;
            total++; if (decode_ready_o !== m_ready()) begin bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, decode_ready_o, m_ready()); end
            step();
            total++; if (issue_valid_o !== mvalid) begin bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, issue_valid_o, mvalid); end
            total++; if (issue_cw_o !== mcw || issue_alu_op1_o !== mop1 || issue_alu_op2_o !== mop2) begin
                bad++; $display("FAIL rnd_word c=%0d got=%h/%h/%h exp=%h/%h/%h", c, issue_cw_o, issue_alu_op1_o,
                                issue_alu_op2_o, mcw, mop1, mop2); end
            total++; if (dut.pending !== m_mask() || int'(dut.count) != m_count()) begin
                bad++; $display("FAIL rnd_sb c=%0d got=%h/%0d exp=%h/%0d", c, dut.pending, dut.count, m_mask(), m_count()); end
        end
        idle();
        step();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        idle();
        @(posedge clk);
        #1;
        test_reset();
        test_add();
        test_raw_forward();
        test_backpressure();
        test_max_in_flight();
        test_x0();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
